flash_read_arbiter: RTL and testbench

FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

---
 rtl/flash_read_arbiter.sv | 78 +++++++
 tb/tb_flash_read_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin arbiter granting two requesters single reads of a shared flash controller
module flash_read_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        req0,
    input  logic [22:0] addr0,
    input  logic        req1,
    input  logic [22:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        flash_start_read,
    output logic [22:0] flash_mem_address,
    input  logic        flash_read_done,
    input  logic [31:0] flash_read_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [7:0]  cnt;
    logic        win;
    // a lone requester wins; on a tie the requester that was not served last wins
    always_comb win = (req0 && req1) ? ~last_owner : req1;
    // read sequencer: arbitrate, pulse start, wait for done or timeout, pulse ack
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            owner             <= 1'b0;
            last_owner        <= 1'b1;
            cnt               <= 8'd0;
            ack0              <= 1'b0;
            ack1              <= 1'b0;
            rdata             <= 32'd0;
            err               <= 1'b0;
            flash_start_read  <= 1'b0;
            flash_mem_address <= 23'd0;
            busy              <= 1'b0;
        end else begin
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            flash_start_read <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    state             <= ISSUE;
                    owner             <= win;
                    last_owner        <= win;
                    flash_mem_address <= win ? addr1 : addr0;
                    flash_start_read  <= 1'b1;
                    busy              <= 1'b1;
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= 8'd0;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (flash_read_done || cnt == 8'(TIMEOUT - 1)) begin
                        state <= DONE;
                        rdata <= flash_read_done ? flash_read_data : 32'd0;
                        err   <= ~flash_read_done;
                        ack0  <= ~owner;
                        ack1  <= owner;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: table-driven reads with an ack scoreboard plus contention, reset and spurious-done sequences
module tb_flash_read_arbiter;
    localparam int TO = 255;
    logic        clk_50M = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [22:0] addr0, addr1;
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic        err;
    logic        flash_start_read;
    logic [22:0] flash_mem_address;
    logic        flash_read_done;
    logic [31:0] flash_read_data;
    logic        busy;
    int          tests = 0;
    int          fails = 0;
    bit          outstanding = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        r0, r1;
        logic [22:0] a0, a1;
        int          n;
        logic [31:0] data;
        logic        own;
        logic [22:0] ea;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    flash_read_arbiter #(.TIMEOUT(TO)) dut (
        .clk_50M(clk_50M), .reset(reset),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .flash_start_read(flash_start_read), .flash_mem_address(flash_mem_address),
        .flash_read_done(flash_read_done), .flash_read_data(flash_read_data),
        .busy(busy)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50M) begin
        exp_t e;
        if (reset) outstanding = 0;
        else begin
            if (flash_start_read) begin
                chk("single_start", outstanding, 0);
                outstanding = 1;
            end
            if (ack0 || ack1) begin
                chk("ack_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ack_owner", {ack1, ack0}, e.owner ? 2'b10 : 2'b01);
                    chk("ack_rdata", rdata, e.rdata);
                    chk("ack_err", err, e.err);
                end
                outstanding = 0;
            end
        end
    end

    task automatic transact(input logic own, input logic [22:0] ea, input int n,
                            input logic [31:0] d, input int lat);
        int   cyc;
        bit   seen;
        exp_t e;
        e.owner = own;
        e.rdata = (n > 0) ? d : 32'h0;
        e.err   = (n == 0);
        exp_q.push_back(e);
        cyc  = 1;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk_50M); #1;
            cyc++;
            seen = flash_start_read;
        end
        chk("start_seen", seen, 1);
        if (!seen) return;
        chk("flash_addr", flash_mem_address, ea);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50M); #1;
            cyc++;
        end
        if (n > 0) begin
            flash_read_done = 1'b1;
            flash_read_data = d;
        end
        seen = 0;
        for (int i = 0; i < TO + 8 && !seen; i++) begin
            @(posedge clk_50M); #1;
            cyc++;
            flash_read_done = 1'b0;
            flash_read_data = 32'h0;
            seen = ack0 | ack1;
        end
        chk("ack_seen", seen, 1);
        if (lat > 0) chk("latency", cyc, lat);
    endtask

    task automatic run_vec(input vec_t v);
        req0  = v.r0;
        req1  = v.r1;
        addr0 = v.a0;
        addr1 = v.a1;
        transact(v.own, v.ea, v.n, v.data, (v.n > 0) ? 3 + v.n : 3 + TO);
        @(posedge clk_50M); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("ack_one_cycle", ack0 | ack1, 0);
        chk("busy_low_after_done", busy, 0);
        @(posedge clk_50M); #1;
        chk("no_reserve", flash_start_read, 0);
        chk("still_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{1, 0, 23'h000100, 23'h000000, 4,  32'hDEADBEEF, 0, 23'h000100};
        vecs[1] = '{0, 1, 23'h000000, 23'h7FFFFF, 1,  32'hA5A5A5A5, 1, 23'h7FFFFF};
        vecs[2] = '{1, 1, 23'h123456, 23'h654321, 3,  32'h0BADF00D, 0, 23'h123456};
        vecs[3] = '{1, 1, 23'h123456, 23'h654321, 2,  32'hCAFEBABE, 1, 23'h654321};
        vecs[4] = '{0, 1, 23'h000000, 23'h00F00F, 0,  32'h00000000, 1, 23'h00F00F};
        vecs[5] = '{1, 0, 23'h3C3C3C, 23'h000000, TO, 32'h12345678, 0, 23'h3C3C3C};
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0;
        flash_read_done = 1'b0;
        flash_read_data = '0;
        repeat (2) @(posedge clk_50M);
        #1;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_start", flash_start_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", flash_mem_address, 0);
        reset = 1'b0;
        @(posedge clk_50M); #1;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 23'h000AAA; addr1 = 23'h000BBB;
        for (int i = 0; i < 4; i++)
            transact(i[0], i[0] ? 23'h000BBB : 23'h000AAA, 2, 32'hC0DE0000 + i, 0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk_50M); #1;
        chk("contention_idle", busy, 0);
        @(posedge clk_50M); #1;
        chk("contention_no_start", flash_start_read, 0);
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        req0 = 1'b1; addr0 = 23'h0ABCDE;
        @(posedge clk_50M); #1;
        chk("midwait_start", flash_start_read, 1);
        repeat (3) @(posedge clk_50M);
        #1;
        reset = 1'b1;
        #1;
        chk("midwait_busy", busy, 0);
        chk("midwait_start_low", flash_start_read, 0);
        chk("midwait_rdata", rdata, 0);
        chk("midwait_err", err, 0);
        chk("midwait_addr", flash_mem_address, 0);
        req0 = 1'b0;
        @(negedge clk_50M);
        @(posedge clk_50M); #1;
        reset = 1'b0;
        flash_read_done = 1'b1;
        flash_read_data = 32'hFFFF0000;
        @(posedge clk_50M); #1;
        flash_read_done = 1'b0;
        flash_read_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_50M); #1;
            chk("stale_done_busy", busy, 0);
            chk("stale_done_ack", ack0 | ack1, 0);
        end
        chk("stale_done_rdata", rdata, 0);
        run_vec('{1, 1, 23'h000777, 23'h000888, 2, 32'h600DCAFE, 0, 23'h000777});
        flash_read_done = 1'b1;
        flash_read_data = 32'hBAD0BAD0;
        @(posedge clk_50M); #1;
        flash_read_done = 1'b0;
        @(posedge clk_50M); #1;
        chk("spurious_rdata", rdata, 32'h600DCAFE);
        chk("spurious_busy", busy, 0);
        chk("spurious_ack", ack0 | ack1, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
